jtag_tap_ctrl: RTL
==================

# jtag_tap_ctrl

Parametrised IEEE 1149.1 TAP controller: 16-state TAP FSM plus instruction register, BYPASS/IDCODE/USER data registers and serial TDO path. It extends the state-only TAP block with real scan behaviour. It sits between the chip-level JTAG pins and on-chip debug/config logic, which sees a parallel user DR with an update strobe.

## Interface

Parameters:
- IR_WIDTH, 4, instruction register width (≥2)
- DR_WIDTH, 8, user data register width (≥1)
- IDCODE_VAL, 32'h1000_0001, value captured by IDCODE (bit 0 must be 1)
- INSTR_IDCODE, 1, IDCODE opcode (zero-extended to IR_WIDTH)
- INSTR_USER, 2, USER opcode; all-ones is always BYPASS

Ports:
- clk  in  1  TCK; all state changes on rising edge
- TRST_n  in  1  asynchronous active-low reset
- TMS  in  1  mode select
- TDI  in  1  serial data in
- TDO  out  1  serial data out
- TDO_en  out  1  high only in Shift_DR / Shift_IR
- state  out  4  current TAP state, encoding below
- ir  out  IR_WIDTH  active instruction
- user_dr_in  in  DR_WIDTH  parallel value captured in Capture_DR under USER
- user_dr_out  out  DR_WIDTH  parallel value loaded in Update_DR under USER
- user_update  out  1  one-cycle strobe, see Timing

## Operation

- State encoding: Test_Logic_Reset 0, Run_Test_Idle 1, Select_DR 2, Capture_DR 3, Shift_DR 4, Exit1_DR 5, Pause_DR 6, Exit2_DR 7, Update_DR 8, Select_IR 9, Capture_IR 10, Shift_IR 11, Exit1_IR 12, Pause_IR 13, Exit2_IR 14, Update_IR 15.
- Transitions per 1149.1: TMS=1 from TLR holds TLR; Select_IR with TMS=1 returns to TLR; Update_* with TMS=1 goes to Select_DR, else Run_Test_Idle; Exit2 with TMS=0 returns to Shift.
- Five consecutive TMS=1 clocks reach TLR from any state.
- IR shift register (IR_WIDTH): Capture_IR loads {0…0,2'b01}; Shift_IR shifts right, TDI into MSB; Update_IR copies to ir.
- In TLR, ir is forced to INSTR_IDCODE every clock.
- DR selection by ir: INSTR_IDCODE → 32-bit IDCODE reg; INSTR_USER → DR_WIDTH user reg; all-ones or any other opcode → 1-bit bypass.
- Capture_DR: bypass ← 0; IDCODE ← IDCODE_VAL; user ← user_dr_in.
- Shift_DR: selected register shifts right, TDI into MSB. Unselected registers hold.
- Update_DR under USER: user_dr_out ← user shift register. Other instructions leave user_dr_out unchanged.
- TDO = LSB of the IR shift register in Shift_IR, LSB of the selected DR in Shift_DR, else 0.

## Timing

- Reset (TRST_n low, asynchronous): state=0, ir=INSTR_IDCODE, all shift regs 0, user_dr_out=0, TDO=0, TDO_en=0, user_update=0. Release is synchronous to the next rising clk.
- Reset mid-shift aborts the scan; user_dr_out is not updated.
- state, ir, shift registers and user_dr_out are registered. TDO, TDO_en and user_update are combinational from registers, so there is no TDI→TDO combinational path.
- In each Shift cycle, TDO shows the bit leaving on that edge. The bench samples TDO before the rising edge.
- user_update is high for exactly the cycle state==Update_DR while ir==INSTR_USER. user_dr_out changes on the same edge that enters Update_DR.
- The last shift occurs on the edge leaving Shift (TMS=1 → Exit1). Exit1, Pause and Exit2 never shift.
- ir changes on the edge entering Update_IR, so the new instruction applies from the next Capture_DR.

## Structure

- Package jtag_pkg: the 4-bit state localparams above, the BYPASS opcode rule, and default opcode constants.
- Sub-module jtag_tap_fsm: next-state logic plus the state register (clk, TRST_n, TMS → state). It is the generalised successor of the state-only TAP.
- The top level holds the IR, DR muxing, shift registers and TDO mux.

## Test plan

- Reset/TLR: pulse TRST_n low mid Shift_DR → state=0, ir=1, user_dr_out=0. From any state, 5×TMS=1 → state=0.
- IDCODE: after reset, TMS 0,1,0,0 then 32 shifts → TDO serialises 32'h1000_0001 LSB first. TDO_en=1 only during those shifts.
- IR capture/load: shift IR with TDI=0,1,0,0 → TDO returns 1,0,0,0 (capture pattern). After Update_IR, ir=4'h2.
- USER round-trip: ir=USER, user_dr_in=8'hA5, shift in 8'h3C → TDO outputs A5 LSB first. In Update_DR, user_dr_out=8'h3C and user_update is high for 1 cycle.
- BYPASS: ir=4'hF, shift TDI pattern 1,0,1,1 → TDO 0,1,0,1 (one-cycle delay). user_dr_out and user_update are unchanged.
- Pause/Exit2 resume: USER shift of 4 bits, Pause 3 cycles, Exit2 → Shift, 4 more bits → user_dr_out equals all 8 shifted bits. No shift occurs in Pause.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, data-register select and opcode helpers.
// Imported by the TAP FSM and the controller top level.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  localparam logic [31:0] DEF_IDCODE_VAL   = 32'h1000_0001;
  localparam int          DEF_INSTR_IDCODE = 1;
  localparam int          DEF_INSTR_USER   = 2;

  // The all-ones opcode of any IR width is BYPASS, whatever else is configured.
  function automatic logic is_bypass_op(input logic [31:0] op, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (op & mask) == mask;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// JTAG pin bundle plus the parallel user-DR side seen by on-chip logic.
// master = board/tester side, slave = the TAP controller.
interface jtag_tap_ctrl_if #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 8
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_en;
  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir;
  logic [DR_WIDTH-1:0] user_dr_in;
  logic [DR_WIDTH-1:0] user_dr_out;
  logic                user_update;

  modport master (
    output TMS, TDI, user_dr_in,
    input  TDO, TDO_en, state, ir, user_dr_out, user_update
  );

  modport slave (
    input  TMS, TDI, user_dr_in,
    output TDO, TDO_en, state, ir, user_dr_out, user_update
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine. Exposes the next state so the
// datapath can act on the edge that enters Update_* or Test_Logic_Reset.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       TRST_n,
  input  logic       TMS,
  output tap_state_e state,
  output tap_state_e state_next
);

  // NOTE: sequential state uses non-blocking assignments and an async reset branch.
  always_ff @(posedge clk or negedge TRST_n) begin
    if (!TRST_n) state <= TLR;
    else         state <= state_next;
  end

  // NOTE: default assigned first so every path drives state_next (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      TLR:    state_next = TMS ? TLR    : RTI;
      RTI:    state_next = TMS ? SEL_DR : RTI;
      SEL_DR: state_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_next = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_next = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_next = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_next = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_next = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_next = TMS ? SEL_DR : RTI;
      SEL_IR: state_next = TMS ? TLR    : CAP_IR;
      CAP_IR: state_next = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_next = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_next = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_next = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_next = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_next = TMS ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: FSM, instruction register, BYPASS/IDCODE/USER data registers
// and the serial TDO mux. TDO is driven from registers only.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter int          DR_WIDTH     = 8,
  parameter logic [31:0] IDCODE_VAL   = DEF_IDCODE_VAL,
  parameter int          INSTR_IDCODE = DEF_INSTR_IDCODE,
  parameter int          INSTR_USER   = DEF_INSTR_USER
) (
  input logic            clk,
  input logic            TRST_n,
  jtag_tap_ctrl_if.slave jtag
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(INSTR_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e          state;
  tap_state_e          state_next;
  dr_sel_e             dr_sel;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic                bypass_q;
  logic [31:0]         idcode_sr;
  logic [DR_WIDTH-1:0] user_sr;
  logic [DR_WIDTH-1:0] user_dr_q;
  logic                tdo;

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .TRST_n     (TRST_n),
    .TMS        (jtag.TMS),
    .state      (state),
    .state_next (state_next)
  );

  always_comb begin
    dr_sel = DR_BYPASS;
    if (is_bypass_op(32'(ir_q), IR_WIDTH)) dr_sel = DR_BYPASS;
    else if (ir_q == OP_IDCODE)            dr_sel = DR_IDCODE;
    else if (ir_q == OP_USER)              dr_sel = DR_USER;
  end

  // Update_IR is entered only from Exit1/Exit2, where ir_sr is idle.
  always_ff @(posedge clk or negedge TRST_n) begin
    if (!TRST_n) begin
      ir_sr <= '0;
      ir_q  <= OP_IDCODE;
    end else begin
      if (state == CAP_IR)     ir_sr <= IR_CAPTURE;
      else if (state == SH_IR) ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};

      if (state_next == TLR)         ir_q <= OP_IDCODE;
      else if (state_next == UPD_IR) ir_q <= ir_sr;
    end
  end

  always_ff @(posedge clk or negedge TRST_n) begin
    if (!TRST_n) begin
      bypass_q  <= 1'b0;
      idcode_sr <= '0;
      user_sr   <= '0;
      user_dr_q <= '0;
    end else begin
      if (state == CAP_DR) begin
        unique case (dr_sel)
          DR_IDCODE: idcode_sr <= IDCODE_VAL;
          DR_USER:   user_sr   <= jtag.user_dr_in;
          default:   bypass_q  <= 1'b0;
        endcase
      end else if (state == SH_DR) begin
        unique case (dr_sel)
          DR_IDCODE: idcode_sr <= {jtag.TDI, idcode_sr[31:1]};
          DR_USER:   user_sr   <= (user_sr >> 1) | (DR_WIDTH'(jtag.TDI) << (DR_WIDTH - 1));
          default:   bypass_q  <= jtag.TDI;
        endcase
      end

      if (state_next == UPD_DR && ir_q == OP_USER) user_dr_q <= user_sr;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_sr[0];
    end else if (state == SH_DR) begin
      unique case (dr_sel)
        DR_IDCODE: tdo = idcode_sr[0];
        DR_USER:   tdo = user_sr[0];
        default:   tdo = bypass_q;
      endcase
    end
  end

  assign jtag.TDO         = tdo;
  assign jtag.TDO_en      = (state == SH_DR) || (state == SH_IR);
  assign jtag.state       = state;
  assign jtag.ir          = ir_q;
  assign jtag.user_dr_out = user_dr_q;
  assign jtag.user_update = (state == UPD_DR) && (ir_q == OP_USER);

endmodule
